// File: rtl/hub75_pkg.sv
// Shared types and panel geometry for the HUB75 scan controller.
package hub75_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    BLANK,
    LATCH,
    DISPLAY
  } scan_state_t;

  localparam int PANEL_COLS      = 32;
  localparam int PANEL_ROW_PAIRS = 16;

  // {r,g,b}, r in bit 2
  typedef logic [2:0] rgb_t;

endpackage

// File: rtl/hub75_scan_ctrl.sv
// HUB75 1/16-scan controller: shifts one row pair of pixels, blanks, updates
// the row address, latches, then holds the row lit for ON_CYCLES clocks.
module hub75_scan_ctrl
  import hub75_pkg::*;
#(
  parameter int COLS      = PANEL_COLS,
  parameter int ROWS      = PANEL_ROW_PAIRS,
  parameter int ON_CYCLES = 256
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  output logic [$clog2(COLS)-1:0]   pix_rd_col,
  output logic [$clog2(ROWS)-1:0]   pix_rd_row,
  input  rgb_t                      pix_upper,
  input  rgb_t                      pix_lower,
  output logic                      r1,
  output logic                      g1,
  output logic                      b1,
  output logic                      r2,
  output logic                      g2,
  output logic                      b2,
  output logic                      A,
  output logic                      B,
  output logic                      C,
  output logic                      D,
  output logic                      LAT,
  output logic                      OEN,
  output logic                      OCLK,
  output logic                      frame_start,
  output scan_state_t               scan_state
);

  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS);
  localparam int OW = $clog2(ON_CYCLES + 1);
  localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
  localparam logic [OW-1:0] ON_LAST  = OW'(ON_CYCLES - 1);

  scan_state_t   state, state_nx;
  logic [CW-1:0] col, col_nx;
  logic [RW-1:0] row, row_nx;
  logic [1:0]    phase, phase_nx;
  logic [OW-1:0] on_cnt, on_cnt_nx;

  rgb_t          rgb_u, rgb_l;
  logic [RW-1:0] addr;
  logic          lat_q, oen_q, oclk_q, fs_q;

  always_comb begin
    state_nx  = state;
    col_nx    = col;
    row_nx    = row;
    phase_nx  = phase;
    on_cnt_nx = on_cnt;
    case (state)
      IDLE: begin
        if (enable) begin
          state_nx = SHIFT;
          col_nx   = '0;
          phase_nx = 2'd0;
        end
      end
      SHIFT: begin
        if (phase == 2'd2) begin
          phase_nx = 2'd0;
          if (col == COL_LAST) begin
            col_nx   = '0;
            state_nx = BLANK;
          end else begin
            col_nx = col + CW'(1);
          end
        end else begin
          phase_nx = phase + 2'd1;
        end
      end
      BLANK: state_nx = LATCH;
      LATCH: begin
        state_nx  = DISPLAY;
        on_cnt_nx = '0;
      end
      DISPLAY: begin
        if (on_cnt == ON_LAST) begin
          on_cnt_nx = '0;
          row_nx    = (row == ROW_LAST) ? '0 : row + RW'(1);
          col_nx    = '0;
          phase_nx  = 2'd0;
          // enable only takes effect at a row boundary, so rows are never cut short
          state_nx  = enable ? SHIFT : IDLE;
        end else begin
          on_cnt_nx = on_cnt + OW'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      col    <= '0;
      row    <= '0;
      phase  <= 2'd0;
      on_cnt <= '0;
      rgb_u  <= '0;
      rgb_l  <= '0;
      addr   <= '0;
      lat_q  <= 1'b0;
      oen_q  <= 1'b1;
      oclk_q <= 1'b0;
      fs_q   <= 1'b0;
    end else begin
      state  <= state_nx;
      col    <= col_nx;
      row    <= row_nx;
      phase  <= phase_nx;
      on_cnt <= on_cnt_nx;
      // Panel strobes are decoded from the next state so they line up with it
      lat_q  <= (state_nx == LATCH);
      oen_q  <= (state_nx != DISPLAY);
      oclk_q <= (state_nx == SHIFT) && (phase_nx == 2'd2);
      fs_q   <= (state != SHIFT) && (state_nx == SHIFT) && (row_nx == '0);
      if (state == SHIFT && phase == 2'd0) begin
        rgb_u <= pix_upper;
        rgb_l <= pix_lower;
      end
      if (state == BLANK) addr <= row;
    end
  end

  assign pix_rd_col   = col;
  assign pix_rd_row   = row;
  assign {r1, g1, b1} = rgb_u;
  assign {r2, g2, b2} = rgb_l;
  assign {D, C, B, A} = 4'(addr);
  assign LAT          = lat_q;
  assign OEN          = oen_q;
  assign OCLK         = oclk_q;
  assign frame_start  = fs_q;
  assign scan_state   = state;

endmodule

// File: tb/tb_hub75_scan_ctrl.sv
// Bench for hub75_scan_ctrl: a position-in-row reference model predicts every
// panel output each cycle under randomized enable and pixel patterns.
module tb_hub75_scan_ctrl;
  import hub75_pkg::*;

  localparam int COLS    = 32;
  localparam int ROWS    = 16;
  localparam int ON      = 256;
  localparam int SHIFT_T = 3 * COLS;
  localparam int ROW_T   = SHIFT_T + 2 + ON;
  localparam int FRAME_T = ROWS * ROW_T;

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic enable = 1'b0;
  always #5 clk = ~clk;

  logic [4:0]  pix_rd_col;
  logic [3:0]  pix_rd_row;
  rgb_t        pix_upper, pix_lower;
  logic        r1, g1, b1, r2, g2, b2, A, B, C, D, LAT, OEN, OCLK, frame_start;
  scan_state_t scan_state;

  hub75_scan_ctrl #(.COLS(COLS), .ROWS(ROWS), .ON_CYCLES(ON)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .pix_rd_col(pix_rd_col), .pix_rd_row(pix_rd_row),
    .pix_upper(pix_upper), .pix_lower(pix_lower),
    .r1(r1), .g1(g1), .b1(b1), .r2(r2), .g2(g2), .b2(b2),
    .A(A), .B(B), .C(C), .D(D),
    .LAT(LAT), .OEN(OEN), .OCLK(OCLK), .frame_start(frame_start),
    .scan_state(scan_state)
  );

  // pixel source
  int   mode = 0;
  rgb_t tab_u[ROWS][COLS];
  rgb_t tab_l[ROWS][COLS];
  assign pix_upper = (mode == 0) ? 3'b100 :
                     (mode == 1) ? pix_rd_col[2:0] : tab_u[pix_rd_row][pix_rd_col];
  assign pix_lower = (mode == 0) ? 3'b001 :
                     (mode == 1) ? (pix_rd_col[2:0] ^ pix_rd_row[2:0]) : tab_l[pix_rd_row][pix_rd_col];

  function automatic rgb_t exp_pix(input bit up, input int r, input int c);
    if (mode == 0) return up ? 3'b100 : 3'b001;
    if (mode == 1) return up ? 3'(c % 8) : (3'(c % 8) ^ 3'(r % 8));
    return up ? tab_u[r][c] : tab_l[r][c];
  endfunction

  // scoreboard
  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // reference model: pos_m is the clock index within the current row, -1 when idle
  int pos_m  = -1;
  int row_m  = 0;
  int addr_m = 0;
  int oclk_rises = 0;
  int lat_pulses = 0;
  logic oclk_prev = 1'b0;
  logic lat_prev  = 1'b0;

  task automatic model_update();
    if (pos_m < 0) begin
      if (enable) pos_m = 0;
    end else begin
      if (pos_m == SHIFT_T) addr_m = row_m;
      if (pos_m == ROW_T - 1) begin
        row_m = (row_m + 1) % ROWS;
        pos_m = enable ? 0 : -1;
      end else begin
        pos_m++;
      end
    end
  endtask

  task automatic model_reset();
    pos_m  = -1;
    row_m  = 0;
    addr_m = 0;
  endtask

  task automatic check_all();
    bit shifting;
    scan_state_t st;
    shifting = (pos_m >= 0) && (pos_m < SHIFT_T);
    if (pos_m < 0)                 st = IDLE;
    else if (shifting)             st = SHIFT;
    else if (pos_m == SHIFT_T)     st = BLANK;
    else if (pos_m == SHIFT_T + 1) st = LATCH;
    else                           st = DISPLAY;
    check("state", 32'(scan_state), 32'(st));
    check("oen", 32'(OEN), 32'(!(pos_m >= SHIFT_T + 2)));
    check("lat", 32'(LAT), 32'(pos_m == SHIFT_T + 1));
    check("oclk", 32'(OCLK), 32'(shifting && (pos_m % 3 == 2)));
    check("frame_start", 32'(frame_start), 32'(pos_m == 0 && row_m == 0));
    check("addr", 32'({D, C, B, A}), 32'(addr_m));
    check("rd_row", 32'(pix_rd_row), 32'(row_m));
    check("rd_col", 32'(pix_rd_col), 32'(shifting ? pos_m / 3 : 0));
    check("lat_oen_overlap", 32'(LAT & ~OEN), 32'(0));
    if (shifting && (pos_m % 3 != 0)) begin
      check("rgb_upper", 32'({r1, g1, b1}), 32'(exp_pix(1'b1, row_m, pos_m / 3)));
      check("rgb_lower", 32'({r2, g2, b2}), 32'(exp_pix(1'b0, row_m, pos_m / 3)));
    end
  endtask

  // driver: one clock, model advance, then checks on the falling edge
  task automatic step();
    @(posedge clk);
    model_update();
    cyc++;
    @(negedge clk);
    check_all();
    if (OCLK && !oclk_prev) oclk_rises++;
    if (LAT && !lat_prev) lat_pulses++;
    oclk_prev = OCLK;
    lat_prev  = LAT;
  endtask

  task automatic wait_frame(input int limit, input string tag);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!frame_start && n < limit);
    check(tag, 32'(frame_start), 32'(1));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_oen"}, 32'(OEN), 32'(1));
    check({tag, "_lat"}, 32'(LAT), 32'(0));
    check({tag, "_oclk"}, 32'(OCLK), 32'(0));
    check({tag, "_fs"}, 32'(frame_start), 32'(0));
    check({tag, "_state"}, 32'(scan_state), 32'(IDLE));
  endtask

  initial begin
    int t0;
    int n;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        tab_u[r][c] = 3'($urandom_range(0, 7));
        tab_l[r][c] = 3'($urandom_range(0, 7));
      end

    // reset, then idle with enable low
    #1 reset = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    check("reset_rgb", 32'({r1, g1, b1, r2, g2, b2}), 32'(0));
    check("reset_addr", 32'({D, C, B, A}), 32'(0));
    reset = 1'b0;
    model_reset();
    repeat (40) step();

    // constant pattern, one full frame with period and strobe counts
    enable = 1'b1;
    wait_frame(10, "fs_first");
    t0 = cyc;
    oclk_rises = 0;
    lat_pulses = 0;
    wait_frame(FRAME_T + 10, "fs_second");
    check("frame_period", 32'(cyc - t0), 32'(FRAME_T));
    check("oclk_per_frame", 32'(oclk_rises), 32'(COLS * ROWS));
    check("lat_per_frame", 32'(lat_pulses), 32'(ROWS));

    // column-derived pattern; drop enable mid-shift of row 5
    mode = 1;
    n = 0;
    while (!(row_m == 5 && pos_m == 30) && n < 3000) begin
      step();
      n++;
    end
    check("reach_row5", 32'(pix_rd_row), 32'(5));
    enable = 1'b0;
    n = 0;
    while (pos_m >= 0 && n < ROW_T + 10) begin
      step();
      n++;
    end
    repeat (20) step();
    check("idle_row", 32'(pix_rd_row), 32'(6));
    check("idle_oen", 32'(OEN), 32'(1));
    mode = 2;
    enable = 1'b1;
    repeat (400) step();

    // randomized enable toggling and pattern changes while idle
    for (int i = 0; i < 15000; i++) begin
      step();
      if ($urandom_range(0, 299) == 0) enable = ~enable;
      if (pos_m < 0 && $urandom_range(0, 3) == 0) mode = $urandom_range(0, 2);
    end

    // asynchronous reset during DISPLAY
    enable = 1'b1;
    n = 0;
    while (pos_m < SHIFT_T + 50 && n < 2 * ROW_T) begin
      step();
      n++;
    end
    check("reach_display", 32'(OEN), 32'(0));
    #2 reset = 1'b1;
    #1 check_reset_outputs("async_reset");
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    wait_frame(5, "fs_after_reset");
    repeat (400) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
